dmem_arbiter: RTL and testbench

Two-requester arbiter and access sequencer in front of the single-port `data_mem` block. The core load/store unit (port 0) and a DMA/debug loader (port 1) each issue requests over valid/ready. The block grants one request at a time and drives the memory's `mem_write`/`addr`/`wdata`/`func3` for exactly one cycle. It then returns the read data and an error flag to the granted requester over a valid/ready response channel. Alignment, `func3` legality and address range are checked before the memory is touched.

---
 rtl/dmem_pkg.sv | 39 +++
 rtl/dmem_arbiter_rr_arb.sv | 50 +++++
 rtl/dmem_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and the request legality check for the dmem_arbiter slice.
package dmem_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } func3_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_e;

  localparam int CHK_ADDR_W = 64;

  // Flags illegal width codes, misaligned halfword/word accesses and out-of-range addresses.
  function automatic logic chk_err(input logic [2:0]            func3,
                                   input logic [CHK_ADDR_W-1:0] addr,
                                   input logic [CHK_ADDR_W-1:0] mem_bytes);
    logic bad_f3;
    logic misal;
    logic oor;
    bad_f3 = 1'b0;
    misal  = 1'b0;
    case (func3)
      F3_B, F3_BU: misal = 1'b0;
      F3_H, F3_HU: misal = addr[0];
      F3_W:        misal = (addr[1:0] != 2'b00);
      default:     bad_f3 = 1'b1;
    endcase
    oor = (addr >= mem_bytes);
    return bad_f3 | misal | oor;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb.sv
// Two-way grant logic: fixed priority (port 0 wins) by default,
// round-robin when DMEM_ARB_RR_EN is defined.
module dmem_rr_arb (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       hs,
  output logic [1:0] gnt
);

`ifdef DMEM_ARB_RR_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  // ptr_q = 1 means port 1 currently has the higher priority
  logic ptr_q;
  logic ptr_d;

  // Grant selection; only a real conflict consults the pointer.
  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = (RR_EN && ptr_q) ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
  end

  // Last-granted port drops to lowest priority after each handshake.
  always_comb begin
    ptr_d = ptr_q;
    if (hs) begin
      ptr_d = gnt[0];
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer in front of the single-port data memory.
// Define DMEM_ARB_RR_EN for round-robin arbitration (fixed priority otherwise).
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rq0_valid,
  output logic              rq0_ready,
  input  logic              rq0_we,
  input  logic [ADDR_W-1:0] rq0_addr,
  input  logic [DATA_W-1:0] rq0_wdata,
  input  logic [2:0]        rq0_func3,
  output logic              rs0_valid,
  input  logic              rs0_ready,
  output logic [DATA_W-1:0] rs0_rdata,
  output logic              rs0_err,
  input  logic              rq1_valid,
  output logic              rq1_ready,
  input  logic              rq1_we,
  input  logic [ADDR_W-1:0] rq1_addr,
  input  logic [DATA_W-1:0] rq1_wdata,
  input  logic [2:0]        rq1_func3,
  output logic              rs1_valid,
  input  logic              rs1_ready,
  output logic [DATA_W-1:0] rs1_rdata,
  output logic              rs1_err,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_func3,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]        mem_func3_q, mem_func3_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rs_valid_q, rs_valid_d;
  logic [1:0]        rs_err_q, rs_err_d;

  logic [1:0]        req_s;
  logic [1:0]        gnt_s;
  logic              hs_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;
  logic [2:0]        sel_func3_s;
  logic              sel_err_s;
  logic              own_ready_s;

  assign req_s = (state_q == IDLE) ? {rq1_valid, rq0_valid} : 2'b00;
  assign hs_s  = |gnt_s;

  dmem_rr_arb u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req_s),
    .hs      (hs_s),
    .gnt     (gnt_s)
  );

  // Payload mux for the granted port plus its legality check.
  always_comb begin
    sel_we_s    = rq0_we;
    sel_addr_s  = rq0_addr;
    sel_wdata_s = rq0_wdata;
    sel_func3_s = rq0_func3;
    if (gnt_s[1]) begin
      sel_we_s    = rq1_we;
      sel_addr_s  = rq1_addr;
      sel_wdata_s = rq1_wdata;
      sel_func3_s = rq1_func3;
    end else begin
      sel_we_s    = rq0_we;
      sel_addr_s  = rq0_addr;
      sel_wdata_s = rq0_wdata;
      sel_func3_s = rq0_func3;
    end
    sel_err_s   = chk_err(sel_func3_s, CHK_ADDR_W'(sel_addr_s), CHK_ADDR_W'(MEM_BYTES));
    own_ready_s = owner_q ? rs1_ready : rs0_ready;
  end

  // Sequencer next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    err_d       = err_q;
    we_d        = we_q;
    mem_write_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_func3_d = mem_func3_q;
    rdata_d     = rdata_q;
    rs_valid_d  = rs_valid_q;
    rs_err_d    = rs_err_q;
    case (state_q)
      IDLE: begin
        if (hs_s) begin
          owner_d     = gnt_s[1];
          err_d       = sel_err_s;
          we_d        = sel_we_s;
          mem_write_d = sel_we_s & ~sel_err_s;
          mem_addr_d  = sel_addr_s;
          mem_wdata_d = sel_wdata_s;
          mem_func3_d = sel_func3_s;
          state_d     = ACCESS;
        end else begin
          state_d     = IDLE;
        end
      end
      ACCESS: begin
        // Memory read is combinational, so the data is valid in this very cycle.
        rdata_d    = (!we_q && !err_q) ? mem_rdata : '0;
        rs_valid_d = owner_q ? 2'b10 : 2'b01;
        rs_err_d   = owner_q ? {err_q, 1'b0} : {1'b0, err_q};
        state_d    = RESP;
      end
      RESP: begin
        if (own_ready_s) begin
          rs_valid_d = 2'b00;
          rs_err_d   = 2'b00;
          rdata_d    = '0;
          state_d    = IDLE;
        end else begin
          state_d    = RESP;
        end
      end
      default: begin
        rs_valid_d = 2'b00;
        rs_err_d   = 2'b00;
        state_d    = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      err_q       <= 1'b0;
      we_q        <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_func3_q <= F3_W;
      rdata_q     <= '0;
      rs_valid_q  <= 2'b00;
      rs_err_q    <= 2'b00;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      err_q       <= err_d;
      we_q        <= we_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_func3_q <= mem_func3_d;
      rdata_q     <= rdata_d;
      rs_valid_q  <= rs_valid_d;
      rs_err_q    <= rs_err_d;
    end
  end

  assign rq0_ready = gnt_s[0];
  assign rq1_ready = gnt_s[1];
  assign rs0_valid = rs_valid_q[0];
  assign rs1_valid = rs_valid_q[1];
  assign rs0_err   = rs_err_q[0];
  assign rs1_err   = rs_err_q[1];
  assign rs0_rdata = rdata_q;
  assign rs1_rdata = rdata_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_func3 = mem_func3_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small byte-addressed memory model.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset_n;
  logic        rq0_valid, rq0_ready, rq0_we;
  logic [31:0] rq0_addr, rq0_wdata;
  logic [2:0]  rq0_func3;
  logic        rs0_valid, rs0_ready, rs0_err;
  logic [31:0] rs0_rdata;
  logic        rq1_valid, rq1_ready, rq1_we;
  logic [31:0] rq1_addr, rq1_wdata;
  logic [2:0]  rq1_func3;
  logic        rs1_valid, rs1_ready, rs1_err;
  logic [31:0] rs1_rdata;
  logic        mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_func3;

  int checks;
  int errors;

  logic [7:0] mem [0:1023];
  logic [9:0] ma;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(1024)) dut (
    .clk(clk), .reset_n(reset_n),
    .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_we(rq0_we), .rq0_addr(rq0_addr),
    .rq0_wdata(rq0_wdata), .rq0_func3(rq0_func3),
    .rs0_valid(rs0_valid), .rs0_ready(rs0_ready), .rs0_rdata(rs0_rdata), .rs0_err(rs0_err),
    .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_we(rq1_we), .rq1_addr(rq1_addr),
    .rq1_wdata(rq1_wdata), .rq1_func3(rq1_func3),
    .rs1_valid(rs1_valid), .rs1_ready(rs1_ready), .rs1_rdata(rs1_rdata), .rs1_err(rs1_err),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_func3(mem_func3), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ma = mem_addr[9:0];

  // Little-endian memory model: combinational read, write on the clock edge.
  always_comb begin
    case (mem_func3)
      3'b000:  mem_rdata = {{24{mem[ma][7]}}, mem[ma]};
      3'b001:  mem_rdata = {{16{mem[ma + 10'd1][7]}}, mem[ma + 10'd1], mem[ma]};
      3'b010:  mem_rdata = {mem[ma + 10'd3], mem[ma + 10'd2], mem[ma + 10'd1], mem[ma]};
      3'b100:  mem_rdata = {24'd0, mem[ma]};
      3'b101:  mem_rdata = {16'd0, mem[ma + 10'd1], mem[ma]};
      default: mem_rdata = 32'd0;
    endcase
  end

  always @(posedge clk) begin
    if (mem_write && mem_addr < 32'd1024) begin
      mem[ma] <= mem_wdata[7:0];
      if (mem_func3[1:0] != 2'b00) mem[ma + 10'd1] <= mem_wdata[15:8];
      if (mem_func3[1:0] == 2'b10) begin
        mem[ma + 10'd2] <= mem_wdata[23:16];
        mem[ma + 10'd3] <= mem_wdata[31:24];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {31'd0, obs}, {31'd0, exp});
  endtask

  task automatic drive(input logic p, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [2:0] f3);
    if (p) begin
      rq1_valid = 1'b1; rq1_we = we; rq1_addr = addr; rq1_wdata = wd; rq1_func3 = f3;
    end else begin
      rq0_valid = 1'b1; rq0_we = we; rq0_addr = addr; rq0_wdata = wd; rq0_func3 = f3;
    end
  endtask

  // One complete transaction on port p, checking every cycle of the sequence.
  task automatic txn(input logic p, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [2:0] f3, input logic [31:0] exp_rd, input logic exp_err,
                     input string tag);
    int n;
    drive(p, we, addr, wd, f3);
    #1;
    n = 0;
    while (!(p ? rq1_ready : rq0_ready) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk1({tag, "_ready"}, p ? rq1_ready : rq0_ready, 1'b1);
    @(posedge clk); #1;
    if (p) rq1_valid = 1'b0; else rq0_valid = 1'b0;
    chk1({tag, "_mw_access"}, mem_write, we & ~exp_err);
    chk1({tag, "_rsv_early"}, p ? rs1_valid : rs0_valid, 1'b0);
    @(posedge clk); #1;
    chk1({tag, "_mw_resp"}, mem_write, 1'b0);
    chk1({tag, "_rsv"}, p ? rs1_valid : rs0_valid, 1'b1);
    chk1({tag, "_rsv_other"}, p ? rs0_valid : rs1_valid, 1'b0);
    chk({tag, "_rdata"}, p ? rs1_rdata : rs0_rdata, exp_rd);
    chk1({tag, "_err"}, p ? rs1_err : rs0_err, exp_err);
    @(posedge clk); #1;
    chk1({tag, "_rsv_done"}, p ? rs1_valid : rs0_valid, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, "_mw"}, mem_write, 1'b0);
    chk({tag, "_maddr"}, mem_addr, 32'd0);
    chk({tag, "_mwdata"}, mem_wdata, 32'd0);
    chk({tag, "_mf3"}, {29'd0, mem_func3}, 32'd2);
    chk1({tag, "_rs0v"}, rs0_valid, 1'b0);
    chk1({tag, "_rs1v"}, rs1_valid, 1'b0);
    chk1({tag, "_rs0e"}, rs0_err, 1'b0);
    chk1({tag, "_rs1e"}, rs1_err, 1'b0);
    chk({tag, "_rs0d"}, rs0_rdata, 32'd0);
    chk({tag, "_rs1d"}, rs1_rdata, 32'd0);
    chk1({tag, "_rq0r"}, rq0_ready, 1'b0);
    chk1({tag, "_rq1r"}, rq1_ready, 1'b0);
  endtask

  initial begin
    logic exp_g;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    reset_n = 1'b0;
    rq0_valid = 1'b0; rq0_we = 1'b0; rq0_addr = 32'd0; rq0_wdata = 32'd0; rq0_func3 = 3'b010;
    rq1_valid = 1'b0; rq1_we = 1'b0; rq1_addr = 32'd0; rq1_wdata = 32'd0; rq1_func3 = 3'b010;
    rs0_ready = 1'b1;
    rs1_ready = 1'b1;

    #12;
    chk_reset_outputs("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Basic store then load on port 0
    txn(1'b0, 1'b1, 32'h04, 32'hFF00FF00, 3'b010, 32'd0, 1'b0, "st_w");
    txn(1'b0, 1'b0, 32'h04, 32'd0, 3'b010, 32'hFF00FF00, 1'b0, "ld_w");

    // Simultaneous requests: port 0 store wins, port 1 load sees the new data
    drive(1'b0, 1'b1, 32'h08, 32'hAAAAAAAA, 3'b010);
    drive(1'b1, 1'b0, 32'h08, 32'd0, 3'b010);
    #1;
    chk1("both_rq0_ready", rq0_ready, 1'b1);
    chk1("both_rq1_ready", rq1_ready, 1'b0);
    @(posedge clk); #1;
    rq0_valid = 1'b0;
    chk1("both_mw", mem_write, 1'b1);
    chk1("both_rq1_blocked", rq1_ready, 1'b0);
    @(posedge clk); #1;
    chk1("both_rs0v", rs0_valid, 1'b1);
    chk1("both_rs0e", rs0_err, 1'b0);
    @(posedge clk); #1;
    chk1("both_rq1_now", rq1_ready, 1'b1);
    @(posedge clk); #1;
    rq1_valid = 1'b0;
    chk1("both_ld_mw", mem_write, 1'b0);
    @(posedge clk); #1;
    chk1("both_rs1v", rs1_valid, 1'b1);
    chk("both_rs1d", rs1_rdata, 32'hAAAAAAAA);
    @(posedge clk); #1;

    // Error cases: nothing written, rdata forced to zero
    txn(1'b1, 1'b1, 32'h06, 32'h12345678, 3'b010, 32'd0, 1'b1, "st_w_mis");
    txn(1'b1, 1'b0, 32'h13, 32'd0, 3'b001, 32'd0, 1'b1, "ld_h_mis");
    txn(1'b1, 1'b0, 32'h00, 32'd0, 3'b011, 32'd0, 1'b1, "f3_ill");
    txn(1'b0, 1'b0, 32'h400, 32'd0, 3'b010, 32'd0, 1'b1, "ld_oor");
    chk("mis_store_untouched", {mem[7], mem[6], mem[5], mem[4]}, 32'hFF00FF00);
    txn(1'b1, 1'b0, 32'h05, 32'd0, 3'b000, 32'hFFFFFFFF, 1'b0, "ld_b");
    txn(1'b1, 1'b0, 32'h05, 32'd0, 3'b100, 32'h000000FF, 1'b0, "ld_bu");

    // Held simultaneous requests: RR alternates, fixed priority starves port 1
    drive(1'b0, 1'b0, 32'h04, 32'd0, 3'b010);
    drive(1'b1, 1'b0, 32'h08, 32'd0, 3'b010);
    for (int k = 0; k < 4; k++) begin
`ifdef DMEM_ARB_RR_EN
      exp_g = (k % 2) == 1;
`else
      exp_g = 1'b0;
`endif
      #1;
      chk1("arb_rq0_ready", rq0_ready, ~exp_g);
      chk1("arb_rq1_ready", rq1_ready, exp_g);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk1("arb_rsv", exp_g ? rs1_valid : rs0_valid, 1'b1);
      chk("arb_rdata", exp_g ? rs1_rdata : rs0_rdata, exp_g ? 32'hAAAAAAAA : 32'hFF00FF00);
      @(posedge clk);
    end
    #1;
    rq0_valid = 1'b0;
    rq1_valid = 1'b0;
    @(posedge clk); #1;

    // Response backpressure: data stable, no new grant
    rs0_ready = 1'b0;
    drive(1'b0, 1'b0, 32'h04, 32'd0, 3'b010);
    drive(1'b1, 1'b0, 32'h08, 32'd0, 3'b010);
    #1;
    chk1("stall_rq0_ready", rq0_ready, 1'b1);
    @(posedge clk); #1;
    rq0_valid = 1'b0;
    chk1("stall_rq1_access", rq1_ready, 1'b0);
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      chk1("stall_rs0v", rs0_valid, 1'b1);
      chk("stall_rs0d", rs0_rdata, 32'hFF00FF00);
      chk1("stall_rq1_ready", rq1_ready, 1'b0);
      @(posedge clk); #1;
    end
    rs0_ready = 1'b1;
    @(posedge clk); #1;
    chk1("stall_rs0v_done", rs0_valid, 1'b0);
    chk1("stall_rq1_served", rq1_ready, 1'b1);
    @(posedge clk); #1;
    rq1_valid = 1'b0;
    @(posedge clk); #1;
    chk1("stall_rs1v", rs1_valid, 1'b1);
    chk("stall_rs1d", rs1_rdata, 32'hAAAAAAAA);
    @(posedge clk); #1;

    // Asynchronous reset during the ACCESS cycle of a store
    drive(1'b0, 1'b1, 32'h10, 32'h12345678, 3'b010);
    #1;
    @(posedge clk); #1;
    rq0_valid = 1'b0;
    chk1("rst_mw_before", mem_write, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    txn(1'b0, 1'b0, 32'h10, 32'd0, 3'b010, 32'd0, 1'b0, "rst_discarded");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
